// File: rtl/e_pkg.sv
// Shared package for the e_* slot-management blocks.
// Holds default widths and the one-hot decoder used for occupancy updates.
package e_pkg;

    // Default slot count and the widths derived from it
    localparam int W_DEF = 32;
    localparam int ID_W  = $clog2(W_DEF);
    localparam int CNT_W = $clog2(W_DEF + 1);

    // Widest one-hot the shared decoder can produce
    localparam int DEC_MAX  = 1024;
    localparam int DEC_ID_W = $clog2(DEC_MAX);

    // Binary index to one-hot; callers truncate the result to their own width
    function automatic logic [DEC_MAX-1:0] dec(input logic [DEC_ID_W-1:0] id);
        logic [DEC_MAX-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/e_single.sv
// Circular free-slot search over an occupancy vector.
// Candidates are visited pos-1, pos-2, ..., 0, W-1, ..., pos (pos itself last);
// the first clear bit in that order is reported.
module e_single
    import e_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic [$clog2(W)-1:0] y_enc_o,
    output logic                 any_o
);

    localparam int IDX_W = $clog2(W);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest free slot wins
    always_comb begin
        y_enc_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = W; k >= 1; k--) begin
            idx = pos_i - IDX_W'(k);
            if (!x_i[idx]) begin
                y_enc_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/e_rr_alloc.sv
// Round-robin slot allocator.
// Owns the occupancy vector and search pointer, grants the next free slot
// with zero latency and retires slots on the free port. Flags are registered
// from the next-state count so they always agree with busy_o.
module e_rr_alloc
    import e_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_req_i,
    output logic                   alloc_gnt_o,
    output logic [$clog2(W)-1:0]   alloc_id_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_id_i,
    output logic [W-1:0]           busy_o,
    output logic [$clog2(W+1)-1:0] cnt_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int IDX_W    = $clog2(W);
    localparam int CNT_BITS = $clog2(W + 1);

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    srch_id;
    logic                srch_any;
    logic                free_ok;
    logic                free_bad;
    logic [W-1:0]        gnt_oh;
    logic [W-1:0]        free_oh;
    logic [W-1:0]        busy_nxt;
    logic [CNT_BITS-1:0] cnt_nxt;

    e_single #(
        .W (W)
    ) u_e_single (
        .x_i     (busy_o),
        .pos_i   (ptr),
        .y_enc_o (srch_id),
        .any_o   (srch_any)
    );

    assign alloc_id_o  = srch_id;
    assign alloc_gnt_o = alloc_req_i & ~rst & srch_any;

    // Classify the free request against pre-edge occupancy
    always_comb begin
        free_ok  = free_vld_i &  busy_o[free_id_i];
        free_bad = free_vld_i & ~busy_o[free_id_i];
    end

    // Next occupancy and count; grant and free never hit the same slot
    always_comb begin
        gnt_oh   = W'(dec({{(DEC_ID_W - IDX_W){1'b0}}, srch_id}));
        free_oh  = W'(dec({{(DEC_ID_W - IDX_W){1'b0}}, free_id_i}));
        busy_nxt = busy_o;
        if (alloc_gnt_o) begin
            busy_nxt = busy_nxt | gnt_oh;
        end
        if (free_ok) begin
            busy_nxt = busy_nxt & ~free_oh;
        end
        cnt_nxt = cnt_o + CNT_BITS'(alloc_gnt_o) - CNT_BITS'(free_ok);
    end

    // State register: occupancy, pointer, count, flags and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o  <= '0;
            ptr     <= '0;
            cnt_o   <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
            err_o   <= 1'b0;
        end else begin
            busy_o  <= busy_nxt;
            if (alloc_gnt_o) begin
                ptr <= srch_id;
            end
            cnt_o   <= cnt_nxt;
            full_o  <= (cnt_nxt == CNT_BITS'(W));
            empty_o <= (cnt_nxt == '0);
            err_o   <= free_bad;
        end
    end

endmodule

// File: tb/tb_e_rr_alloc.sv
// Directed testbench for e_rr_alloc with W=16.
module tb_e_rr_alloc;

    localparam int W = 16;

    logic        clk;
    logic        rst;
    logic        alloc_req_i;
    logic        alloc_gnt_o;
    logic [3:0]  alloc_id_o;
    logic        free_vld_i;
    logic [3:0]  free_id_i;
    logic [15:0] busy_o;
    logic [4:0]  cnt_o;
    logic        full_o;
    logic        empty_o;
    logic        err_o;

    int vectors;
    int miscompares;

    e_rr_alloc #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req_i (alloc_req_i),
        .alloc_gnt_o (alloc_gnt_o),
        .alloc_id_o  (alloc_id_o),
        .free_vld_i  (free_vld_i),
        .free_id_i   (free_id_i),
        .busy_o      (busy_o),
        .cnt_o       (cnt_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req_i = 1'b0;
        free_vld_i  = 1'b0;
        free_id_i   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b want 0", alloc_gnt_o);
        end
        tick();
        tick();
        rst = 1'b0;
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'h0000 || cnt_o !== 5'd0 || full_o !== 1'b0 ||
            empty_o !== 1'b1 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%h cnt=%0d full=%b empty=%b err=%b want 0000 0 0 1 0",
                     busy_o, cnt_o, full_o, empty_o, err_o);
        end
    endtask

    task automatic test_three_grants();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_req_i = 1'b1;
            #1;
            vectors++;
            if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'(15 - i)) begin
                miscompares++;
                $display("FAIL grant_%0d: gnt=%b id=%0d want 1 %0d", i, alloc_gnt_o, alloc_id_o, 15 - i);
            end
            tick();
        end
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'hE000 || cnt_o !== 5'd3 || empty_o !== 1'b0 || full_o !== 1'b0) begin
            miscompares++;
            $display("FAIL three_state: busy=%h cnt=%0d empty=%b full=%b want e000 3 0 0",
                     busy_o, cnt_o, empty_o, full_o);
        end
    endtask

    // Continues from test_three_grants: busy=e000, ptr=13
    task automatic test_grant_and_free();
        alloc_req_i = 1'b1;
        free_vld_i  = 1'b1;
        free_id_i   = 4'd15;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd12) begin
            miscompares++;
            $display("FAIL gf_grant: gnt=%b id=%0d want 1 12", alloc_gnt_o, alloc_id_o);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (busy_o !== 16'h7000 || cnt_o !== 5'd3 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL gf_state: busy=%h cnt=%0d err=%b want 7000 3 0", busy_o, cnt_o, err_o);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_req_i = 1'b1;
            #1;
            vectors++;
            if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'(15 - i)) begin
                miscompares++;
                $display("FAIL fill_%0d: gnt=%b id=%0d want 1 %0d", i, alloc_gnt_o, alloc_id_o, 15 - i);
            end
            tick();
        end
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'hFFFF || cnt_o !== 5'd16 || full_o !== 1'b1 || empty_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_state: busy=%h cnt=%0d full=%b empty=%b want ffff 16 1 0",
                     busy_o, cnt_o, full_o, empty_o);
        end
    endtask

    task automatic test_full_reject();
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_gnt: got %b want 0", alloc_gnt_o);
        end
        tick();
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'hFFFF || cnt_o !== 5'd16) begin
            miscompares++;
            $display("FAIL full_hold: busy=%h cnt=%0d want ffff 16", busy_o, cnt_o);
        end
    endtask

    // Starts full with ptr=0
    task automatic test_full_free_same_cycle();
        free_vld_i  = 1'b1;
        free_id_i   = 4'd14;
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ffs_gnt: got %b want 0", alloc_gnt_o);
        end
        tick();
        free_vld_i = 1'b0;
        #1;
        vectors++;
        if (cnt_o !== 5'd15 || full_o !== 1'b0 || busy_o !== 16'hBFFF) begin
            miscompares++;
            $display("FAIL ffs_state: cnt=%0d full=%b busy=%h want 15 0 bfff", cnt_o, full_o, busy_o);
        end
        vectors++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd14) begin
            miscompares++;
            $display("FAIL ffs_regrant: gnt=%b id=%0d want 1 14", alloc_gnt_o, alloc_id_o);
        end
        tick();
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (full_o !== 1'b1 || cnt_o !== 5'd16) begin
            miscompares++;
            $display("FAIL ffs_refull: full=%b cnt=%0d want 1 16", full_o, cnt_o);
        end
    endtask

    // Starts full with ptr=0
    task automatic test_circular_order();
        free_vld_i = 1'b1;
        free_id_i  = 4'd2;
        tick();
        free_id_i  = 4'd10;
        tick();
        free_vld_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'hFBFB || cnt_o !== 5'd14) begin
            miscompares++;
            $display("FAIL circ_state: busy=%h cnt=%0d want fbfb 14", busy_o, cnt_o);
        end
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd10) begin
            miscompares++;
            $display("FAIL circ_first: gnt=%b id=%0d want 1 10", alloc_gnt_o, alloc_id_o);
        end
        tick();
        vectors++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd2) begin
            miscompares++;
            $display("FAIL circ_second: gnt=%b id=%0d want 1 2", alloc_gnt_o, alloc_id_o);
        end
        tick();
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (cnt_o !== 5'd16 || full_o !== 1'b1) begin
            miscompares++;
            $display("FAIL circ_refull: cnt=%0d full=%b want 16 1", cnt_o, full_o);
        end
    endtask

    task automatic test_invalid_free();
        do_reset();
        free_vld_i = 1'b1;
        free_id_i  = 4'd3;
        tick();
        free_vld_i = 1'b0;
        #1;
        vectors++;
        if (err_o !== 1'b1 || busy_o !== 16'h0000 || cnt_o !== 5'd0 || empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL badfree_pulse: err=%b busy=%h cnt=%0d empty=%b want 1 0000 0 1",
                     err_o, busy_o, cnt_o, empty_o);
        end
        tick();
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL badfree_clear: err=%b want 0", err_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (cnt_o !== 5'd5 || busy_o !== 16'hF800) begin
            miscompares++;
            $display("FAIL mid_hold: cnt=%0d busy=%h want 5 f800", cnt_o, busy_o);
        end
        rst = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_gnt: got %b want 0", alloc_gnt_o);
        end
        tick();
        rst = 1'b0;
        alloc_req_i = 1'b0;
        #1;
        vectors++;
        if (busy_o !== 16'h0000 || cnt_o !== 5'd0 || empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_state: busy=%h cnt=%0d empty=%b want 0000 0 1", busy_o, cnt_o, empty_o);
        end
        alloc_req_i = 1'b1;
        #1;
        vectors++;
        if (alloc_gnt_o !== 1'b1 || alloc_id_o !== 4'd15) begin
            miscompares++;
            $display("FAIL mid_first: gnt=%b id=%0d want 1 15", alloc_gnt_o, alloc_id_o);
        end
        tick();
        alloc_req_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_three_grants();
        test_grant_and_free();
        test_fill();
        test_full_reject();
        test_full_free_same_cycle();
        test_fill();
        test_circular_order();
        test_invalid_free();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
